// File: rtl/tx_doorbell_arb.sv
// Doorbell arbiter: memory-mapped per-channel payload registers drained
// round-robin onto a single valid/ready transmit port.

module tx_doorbell_ch #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              acc,
  input  logic              grant,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic              pending,
  output logic              overflow,
  output logic [DATA_W-1:0] hold
);
  // A write that lands while the channel is being granted refills the slot
  // instead of being counted as a drop.
  logic load, drop;
  assign load = acc && (!pending || grant);
  assign drop = acc && pending && !grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending  <= 1'b0;
      overflow <= 1'b0;
      hold     <= '0;
    end else begin
      if (load) begin
        hold    <= din;
        pending <= 1'b1;
      end else if (grant) begin
        pending <= 1'b0;
      end
      overflow <= drop | (overflow & ~clr);
    end
  end
endmodule

module tx_doorbell_arb #(
  parameter int          N_CH      = 4,
  parameter logic [31:0] BASE_ADDR = 32'd1044,
  parameter int          DATA_W    = 8,
  parameter int          CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              DM_W,
  input  logic [31:0]       wdata,
  output logic [N_CH-1:0]   trans_ena,
  output logic [N_CH-1:0]   pending,
  output logic [N_CH-1:0]   overflow,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic [CH_W-1:0]   tx_chan
);
  localparam int N_DEC = N_CH + 1;

  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nxt;

  logic [N_DEC-1:0]             hit, armed, acc;
  logic [N_CH-1:0]              grant, clr;
  logic [N_CH-1:0][DATA_W-1:0]  hold;
  logic [CH_W-1:0]              last_grant, grant_idx;
  logic                         grant_vld, take;
  logic                         unused_wdata;

  assign unused_wdata = ^wdata;

  // Index N_CH is the overflow control register.
  for (genvar k = 0; k < N_DEC; k++) begin : g_dec
    assign hit[k] = DM_W && (addr == BASE_ADDR + 32'(4 * k));
  end

  // Armed tracks "hit last cycle", so a held write is accepted only once.
  assign acc = hit & ~armed;
  assign clr = acc[N_CH] ? wdata[N_CH-1:0] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed     <= '0;
      trans_ena <= '0;
    end else begin
      armed     <= hit;
      trans_ena <= acc[N_CH-1:0];
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign grant[i] = take && (grant_idx == CH_W'(i));
    tx_doorbell_ch #(.DATA_W(DATA_W)) u_ch (
      .clk      (clk),
      .reset    (reset),
      .acc      (acc[i]),
      .grant    (grant[i]),
      .clr      (clr[i]),
      .din      (wdata[DATA_W-1:0]),
      .pending  (pending[i]),
      .overflow (overflow[i]),
      .hold     (hold[i])
    );
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant;
    for (int k = 1; k <= N_CH; k++) begin
      int c;
      c = int'(last_grant) + k;
      if (c >= N_CH) c = c - N_CH;
      if (!grant_vld && pending[CH_W'(c)]) begin
        grant_vld = 1'b1;
        grant_idx = CH_W'(c);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = SEND;
      SEND:    if (tx_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_valid = (state == SEND);
    take     = (state == IDLE) && grant_vld;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data    <= '0;
      tx_chan    <= '0;
      last_grant <= CH_W'(N_CH - 1);
    end else if (take) begin
      tx_data    <= hold[grant_idx];
      tx_chan    <= grant_idx;
      last_grant <= grant_idx;
    end
  end
endmodule

// File: tb/tb_tx_doorbell_arb.sv
// Directed bench for tx_doorbell_arb: reset, single/held writes, round-robin,
// overflow and same-cycle refill, reset during SEND and reset release.

module tb_tx_doorbell_arb;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        DM_W;
  logic [31:0] wdata;
  logic [3:0]  trans_ena, pending, overflow;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic [1:0]  tx_chan;

  int pass_cnt = 0;
  int total    = 0;

  tx_doorbell_arb dut (
    .clk(clk), .reset(reset), .addr(addr), .DM_W(DM_W), .wdata(wdata),
    .trans_ena(trans_ena), .pending(pending), .overflow(overflow),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_chan(tx_chan)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; DM_W = 1'b1;
    step();
    DM_W = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; DM_W = 1'b0; tx_ready = 1'b0; addr = '0; wdata = '0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; DM_W = 1'b0; tx_ready = 1'b0; addr = '0; wdata = '0;
    #2;
    total++; if (trans_ena !== 4'b0) $display("FAIL reset_trans_ena got=%b exp=0", trans_ena); else pass_cnt++;
    total++; if (pending !== 4'b0) $display("FAIL reset_pending got=%b exp=0", pending); else pass_cnt++;
    total++; if (overflow !== 4'b0) $display("FAIL reset_overflow got=%b exp=0", overflow); else pass_cnt++;
    total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); else pass_cnt++;
    total++; if ({tx_data, tx_chan} !== 10'b0) $display("FAIL reset_tx_data_chan got=%h/%0d exp=0/0", tx_data, tx_chan); else pass_cnt++;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic test_single();
    tx_ready = 1'b1;
    wr(32'd1044, 32'h5A);
    total++; if (trans_ena !== 4'b0001) $display("FAIL single_trans_ena got=%b exp=0001", trans_ena); else pass_cnt++;
    total++; if (pending !== 4'b0001) $display("FAIL single_pending got=%b exp=0001", pending); else pass_cnt++;
    total++; if (tx_valid !== 1'b0) $display("FAIL single_valid_early got=%b exp=0", tx_valid); else pass_cnt++;
    step();
    total++; if (trans_ena !== 4'b0) $display("FAIL single_trans_ena_pulse got=%b exp=0", trans_ena); else pass_cnt++;
    total++; if (tx_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", tx_valid); else pass_cnt++;
    total++; if (tx_data !== 8'h5A) $display("FAIL single_data got=%h exp=5a", tx_data); else pass_cnt++;
    total++; if (tx_chan !== 2'd0) $display("FAIL single_chan got=%0d exp=0", tx_chan); else pass_cnt++;
    total++; if (pending !== 4'b0) $display("FAIL single_pending_clr got=%b exp=0", pending); else pass_cnt++;
    step();
    total++; if (tx_valid !== 1'b0) $display("FAIL single_valid_drop got=%b exp=0", tx_valid); else pass_cnt++;
  endtask

  task automatic test_held();
    int pulses = 0, hs = 0;
    logic [7:0] seen = '0;
    tx_ready = 1'b1;
    addr = 32'd1048; wdata = 32'h33; DM_W = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) DM_W = 1'b0;
      step();
      if (trans_ena[1]) pulses++;
      if (tx_valid && tx_ready) begin hs++; seen = tx_data; end
    end
    total++; if (pulses != 1) $display("FAIL held_pulses got=%0d exp=1", pulses); else pass_cnt++;
    total++; if (hs != 1) $display("FAIL held_payloads got=%0d exp=1", hs); else pass_cnt++;
    total++; if (seen !== 8'h33) $display("FAIL held_data got=%h exp=33", seen); else pass_cnt++;
    total++; if (overflow !== 4'b0) $display("FAIL held_overflow got=%b exp=0", overflow); else pass_cnt++;
  endtask

  // Channel 3 reaches an idle output first and is granted at once; the other
  // two then drain from channel 0 upward: 3, 1, 2.
  task automatic test_round_robin();
    int n = 0;
    logic [1:0] ord[3];
    logic [7:0] dat[3];
    do_reset();
    wr(32'd1056, 32'h03);
    total++; if (pending !== 4'b1000) $display("FAIL rr_pending3 got=%b exp=1000", pending); else pass_cnt++;
    wr(32'd1048, 32'h01);
    wr(32'd1052, 32'h02);
    total++; if (pending !== 4'b0110) $display("FAIL rr_pending12 got=%b exp=0110", pending); else pass_cnt++;
    total++; if (tx_valid !== 1'b1 || tx_chan !== 2'd3 || tx_data !== 8'h03)
      $display("FAIL rr_stall got=%b/%0d/%h exp=1/3/03", tx_valid, tx_chan, tx_data); else pass_cnt++;
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (tx_valid && tx_ready && n < 3) begin ord[n] = tx_chan; dat[n] = tx_data; n++; end
      step();
    end
    total++; if (n != 3) $display("FAIL rr_count got=%0d exp=3", n); else pass_cnt++;
    total++; if ({ord[0], ord[1], ord[2]} !== {2'd3, 2'd1, 2'd2})
      $display("FAIL rr_order got=%0d,%0d,%0d exp=3,1,2", ord[0], ord[1], ord[2]); else pass_cnt++;
    total++; if ({dat[0], dat[1], dat[2]} !== 24'h030102)
      $display("FAIL rr_data got=%h,%h,%h exp=03,01,02", dat[0], dat[1], dat[2]); else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    wr(32'd1048, 32'h11);
    step();
    total++; if (tx_valid !== 1'b1 || tx_chan !== 2'd1) $display("FAIL ovf_busy got=%b/%0d exp=1/1", tx_valid, tx_chan); else pass_cnt++;
    wr(32'd1044, 32'hA0);
    step();
    wr(32'd1044, 32'hB0);
    total++; if (overflow !== 4'b0001) $display("FAIL ovf_set got=%b exp=0001", overflow); else pass_cnt++;
    total++; if (pending !== 4'b0001) $display("FAIL ovf_pending got=%b exp=0001", pending); else pass_cnt++;
    wr(32'd1060, 32'hF0);
    total++; if (overflow !== 4'b0001) $display("FAIL ovf_hi_bits got=%b exp=0001", overflow); else pass_cnt++;
    total++; if (trans_ena !== 4'b0) $display("FAIL ovf_ctrl_trans got=%b exp=0", trans_ena); else pass_cnt++;
    step();
    wr(32'd1060, 32'h01);
    total++; if (overflow !== 4'b0) $display("FAIL ovf_clear got=%b exp=0", overflow); else pass_cnt++;
    tx_ready = 1'b1;
    total++; if (tx_data !== 8'h11) $display("FAIL ovf_ch1_data got=%h exp=11", tx_data); else pass_cnt++;
    step();
    total++; if (tx_valid !== 1'b0) $display("FAIL ovf_no_grant_on_hs got=%b exp=0", tx_valid); else pass_cnt++;
    // Refill channel 0 in the same edge it gets granted.
    tx_ready = 1'b0;
    wr(32'd1044, 32'hC0);
    total++; if (tx_valid !== 1'b1 || tx_chan !== 2'd0 || tx_data !== 8'hA0)
      $display("FAIL ovf_retained got=%b/%0d/%h exp=1/0/a0", tx_valid, tx_chan, tx_data); else pass_cnt++;
    total++; if (pending !== 4'b0001) $display("FAIL refill_pending got=%b exp=0001", pending); else pass_cnt++;
    total++; if (overflow !== 4'b0) $display("FAIL refill_overflow got=%b exp=0", overflow); else pass_cnt++;
    tx_ready = 1'b1;
    step(); step();
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'hC0) $display("FAIL refill_data got=%b/%h exp=1/c0", tx_valid, tx_data); else pass_cnt++;
    step();
    total++; if (pending !== 4'b0 || tx_valid !== 1'b0) $display("FAIL refill_drain got=%b/%b exp=0000/0", pending, tx_valid); else pass_cnt++;
  endtask

  task automatic test_reset_send();
    int late = 0;
    do_reset();
    wr(32'd1052, 32'h77);
    step();
    total++; if (tx_valid !== 1'b1) $display("FAIL rs_valid got=%b exp=1", tx_valid); else pass_cnt++;
    reset = 1'b0;
    #1;
    total++; if ({trans_ena, pending, overflow, tx_valid, tx_data, tx_chan} !== 23'b0)
      $display("FAIL rs_outputs got=%b/%b/%b/%b/%h/%0d exp=all 0", trans_ena, pending, overflow, tx_valid, tx_data, tx_chan); else pass_cnt++;
    step();
    reset = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (tx_valid) late++;
    end
    total++; if (late != 0) $display("FAIL rs_no_tx got=%0d exp=0", late); else pass_cnt++;
  endtask

  task automatic test_reset_release();
    tx_ready = 1'b1;
    addr = 32'd1044; wdata = 32'h42; DM_W = 1'b1;
    step();
    step();
    total++; if (trans_ena !== 4'b0) $display("FAIL rr_armed got=%b exp=0", trans_ena); else pass_cnt++;
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    total++; if (trans_ena !== 4'b0001) $display("FAIL release_accept got=%b exp=0001", trans_ena); else pass_cnt++;
    DM_W = 1'b0;
    step();
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) $display("FAIL release_tx got=%b/%h exp=1/42", tx_valid, tx_data); else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_held();
    test_round_robin();
    test_overflow();
    test_reset_send();
    test_reset_release();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
